// File: rtl/rx_comma_aligner_pkg.sv
// Shared definitions for the receive-side comma aligner.
//   SYM_W          : 8b/10b symbol width
//   K28_5_RDN/RDP  : K28.5 comma in both running disparities
//   LOCK_CNT_DEF   : default on-boundary commas needed to lock
//   LOSS_CNT_DEF   : default off-boundary commas that drop lock
//   align_state_t  : aligner state (HUNT, VERIFY, LOCKED)
package rx_comma_aligner_pkg;

  localparam int unsigned SYM_W        = 10;
  localparam logic [9:0]  K28_5_RDN    = 10'b0011111010;
  localparam logic [9:0]  K28_5_RDP    = 10'b1100000101;
  localparam int unsigned LOCK_CNT_DEF = 3;
  localparam int unsigned LOSS_CNT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage

// File: rtl/rx_comma_aligner.sv
// Receive word aligner for one serial lane. Shifts in one bit per enabled
// cycle, hunts for a K28.5 comma in either disparity and locks the 10-bit
// symbol boundary. Once locked, each symbol completed on the boundary is
// presented on sym_o with a one-cycle sym_valid_o strobe.
// Ports:
//   clk          : clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   ser_i        : serial bit, MSB of the symbol first
//   ser_valid_i  : ser_i is taken only when this is 1
//   sym_o        : aligned symbol, held between strobes
//   sym_valid_o  : one-cycle strobe, new symbol on sym_o (LOCKED only)
//   comma_o      : with sym_valid_o, the symbol is a K28.5 comma
//   locked_o     : 1 while the aligner is locked
//   realign_o    : one-cycle pulse whenever the symbol boundary moves
module rx_comma_aligner
  import rx_comma_aligner_pkg::*;
#(
  parameter int unsigned      SYM_W     = rx_comma_aligner_pkg::SYM_W,
  parameter logic [SYM_W-1:0] COMMA_RDN = K28_5_RDN,
  parameter logic [SYM_W-1:0] COMMA_RDP = K28_5_RDP,
  parameter int unsigned      LOCK_CNT  = LOCK_CNT_DEF,
  parameter int unsigned      LOSS_CNT  = LOSS_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_i,
  input  logic             ser_valid_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  output logic             comma_o,
  output logic             locked_o,
  output logic             realign_o
);

  localparam logic [3:0] LAST_BIT = 4'(SYM_W - 1);
  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_TGT = 3'(LOSS_CNT);

  function automatic logic is_comma(input logic [SYM_W-1:0] w);
    return (w == COMMA_RDN) || (w == COMMA_RDP);
  endfunction

  logic [SYM_W-1:0] sr_reg;
  logic [3:0]       bit_cnt_reg;
  logic [2:0]       good_cnt_reg;
  logic [2:0]       bad_cnt_reg;
  align_state_t     state_reg;

  // Window including the bit being accepted this cycle; comma detection and
  // symbol capture both look at it so no extra cycle of latency is added.
  logic [SYM_W-1:0] nsr;
  logic             cm;
  logic             bnd;

  assign nsr = {sr_reg[SYM_W-2:0], ser_i};
  assign cm  = is_comma(nsr);
  assign bnd = (bit_cnt_reg == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg       <= '0;
      bit_cnt_reg  <= '0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
      state_reg    <= HUNT;
      sym_o        <= '0;
      sym_valid_o  <= 1'b0;
      comma_o      <= 1'b0;
      locked_o     <= 1'b0;
      realign_o    <= 1'b0;
    end else begin
      sym_valid_o <= 1'b0;
      comma_o     <= 1'b0;
      realign_o   <= 1'b0;
      if (ser_valid_i) begin
        sr_reg      <= nsr;
        bit_cnt_reg <= bnd ? 4'd0 : bit_cnt_reg + 4'd1;
        unique case (state_reg)
          HUNT: begin
            if (cm) begin
              // This bit becomes the last bit of a symbol.
              bit_cnt_reg <= '0;
              realign_o   <= 1'b1;
              if (LOCK_TGT == 3'd1) begin
                state_reg    <= LOCKED;
                locked_o     <= 1'b1;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
              end else begin
                state_reg    <= VERIFY;
                good_cnt_reg <= 3'd1;
              end
            end
          end
          VERIFY: begin
            if (cm && bnd) begin
              if (good_cnt_reg + 3'd1 == LOCK_TGT) begin
                state_reg    <= LOCKED;
                locked_o     <= 1'b1;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
              end else begin
                good_cnt_reg <= good_cnt_reg + 3'd1;
              end
            end else if (cm) begin
              // Comma at a different phase: restart verification there.
              bit_cnt_reg  <= '0;
              realign_o    <= 1'b1;
              good_cnt_reg <= 3'd1;
            end
          end
          LOCKED: begin
            if (bnd) begin
              sym_o       <= nsr;
              sym_valid_o <= 1'b1;
              comma_o     <= cm;
              if (cm) begin
                bad_cnt_reg <= '0;
              end
            end else if (cm) begin
              // Off-boundary comma: count it but keep the current boundary.
              if (bad_cnt_reg + 3'd1 == LOSS_TGT) begin
                state_reg    <= HUNT;
                locked_o     <= 1'b0;
                bad_cnt_reg  <= '0;
                good_cnt_reg <= '0;
              end else begin
                bad_cnt_reg <= bad_cnt_reg + 3'd1;
              end
            end
          end
          default: begin
            state_reg <= HUNT;
            locked_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
